// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer. Holds the 64-bit mtime/mtimecmp pair,
// answers a valid/ready register bus and raises the level interrupt ti while
// mtime >= mtimecmp.
module clint_timer #(
    parameter int unsigned PRESC_DIV = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ti
);

    localparam int unsigned   PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_SNAP     = 3'd5;

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          en;
    logic [PW-1:0] presc;
    logic [31:0]   snap;

    logic          accept;
    logic [2:0]    off;
    logic          in_window;
    logic          mapped;
    logic          wr_acc;
    logic          wr_mtime_lo;
    logic          wr_mtime_hi;
    logic          wr_cmp_lo;
    logic          wr_cmp_hi;
    logic          wr_ctrl;
    logic          rd_mtime_lo;
    logic          tick;
    logic [31:0]   rd_data;
    logic          unused_addr;

    // Only one request may be outstanding, so the bus stalls while a response waits.
    assign req_ready = ~resp_valid;
    assign accept    = req_valid & req_ready;

    // Address decode: 32-byte window, word offsets 0..5 mapped, addr[1:0] ignored.
    assign off         = req_addr[4:2];
    assign in_window   = (req_addr[31:5] == BASE_ADDR[31:5]);
    assign mapped      = in_window & (off <= OFF_SNAP);
    assign unused_addr = ^req_addr[1:0];

    assign wr_acc      = accept & req_we & in_window;
    assign wr_mtime_lo = wr_acc & (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr_acc & (off == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr_acc & (off == OFF_CMP_LO);
    assign wr_cmp_hi   = wr_acc & (off == OFF_CMP_HI);
    assign wr_ctrl     = wr_acc & (off == OFF_CTRL);
    assign rd_mtime_lo = accept & ~req_we & in_window & (off == OFF_MTIME_LO);

    // One mtime increment per PRESC_DIV enabled cycles.
    assign tick = en & (presc == PRESC_LAST);

    // Read mux over pre-update register values; writes and unmapped offsets read as zero.
    always_comb begin
        rd_data = 32'd0;
        if (mapped & ~req_we) begin
            case (off)
                OFF_MTIME_LO: rd_data = mtime[31:0];
                OFF_MTIME_HI: rd_data = mtime[63:32];
                OFF_CMP_LO:   rd_data = mtimecmp[31:0];
                OFF_CMP_HI:   rd_data = mtimecmp[63:32];
                OFF_CTRL:     rd_data = {31'd0, en};
                OFF_SNAP:     rd_data = snap;
                default:      rd_data = 32'd0;
            endcase
        end
    end

    // Prescaler: free-runs while enabled, restarts from zero when re-enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (wr_ctrl & ~en & req_wdata[0]) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Enable bit; only bit 0 of ctrl is implemented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en <= 1'b1;
        end else if (wr_ctrl) begin
            en <= req_wdata[0];
        end
    end

    // mtime: a bus write replaces its half and suppresses that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= req_wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= req_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves written independently; resets to the never-fire value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= req_wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= req_wdata;
        end
    end

    // Snapshot of the high word taken when the low word is read, for coherent 64-bit reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= 32'd0;
        end else if (rd_mtime_lo) begin
            snap <= mtime[63:32];
        end
    end

    // Response register: loaded on accept, held until the initiator takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= rd_data;
            resp_err   <= ~mapped;
        end else if (resp_valid & resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Interrupt compare on the registered values, so ti lags a register change by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ti <= 1'b0;
        end else begin
            ti <= (mtime >= mtimecmp);
        end
    end

endmodule
